// File: rtl/winner_policy_param.sv
// Epsilon-greedy next-hop selector: explore picks a random better neighbour and decays epsilon, exploit applies hysteresis.
// Optional macro WINNER_POLICY_STATS_EN adds saturating explore_count/exploit_count outputs.
module winner_policy_param #(
  parameter int          WORD_WIDTH     = 16,
  parameter int          ADDR_WIDTH     = 11,
  parameter int          RNG_WIDTH      = 4,
  parameter int          EPS_ADDR       = 'h004,
  parameter int          NBR_COUNT_ADDR = 'h68C,
  parameter int          NBR_BASE_ADDR  = 'h668,
  parameter int          NBR_STRIDE     = 2,
  parameter int          MAX_NEIGHBORS  = 16,
  parameter logic [15:0] HYST_DN        = 16'hFFBE,
  parameter logic [15:0] HYST_UP        = 16'h0042,
  parameter int          EPS_MIN        = 0,
  parameter int          NO_HOP         = 65
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] mybest,
  input  logic [WORD_WIDTH-1:0] bestvalue,
  input  logic [WORD_WIDTH-1:0] besthop,
  input  logic [WORD_WIDTH-1:0] bestneighborID,
  input  logic [WORD_WIDTH-1:0] my_node_id,
  input  logic [WORD_WIDTH-1:0] epsilon_step,
  input  logic [RNG_WIDTH-1:0]  rng_in,
  output logic                  rng_en,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] nexthop,
  output logic                  explored,
  output logic                  busy,
  output logic                  done
`ifdef WINNER_POLICY_STATS_EN
  ,
  output logic [15:0]           explore_count,
  output logic [15:0]           exploit_count
`endif
);

  localparam int CW = $clog2(MAX_NEIGHBORS + 1);
  localparam int MW = (RNG_WIDTH > CW) ? RNG_WIDTH : CW;
  localparam int PW = 2 * WORD_WIDTH + 1;

  typedef enum logic [3:0] {
    IDLE, EPS_RD, DECIDE, CNT_RD, CNT_WAIT, MOD, NBR_RD, NBR_WAIT, EPS_WR, EXP_MUL, EXP_CMP, DONE
  } state_t;

  state_t                state, state_nxt;
  logic [RNG_WIDTH-1:0]  draw, pick;
  logic [WORD_WIDTH-1:0] eps;
  logic [CW-1:0]         cnt;
  logic [PW-1:0]         l_val, rdn, rup;

  logic [CW-1:0]         cnt_clamped;
  logic                  pick_ge;
  logic                  explore_draw;
  logic [ADDR_WIDTH-1:0] nbr_addr;
  logic [WORD_WIDTH-1:0] eps_next;

  always_comb begin
    cnt_clamped  = (data_in > WORD_WIDTH'(MAX_NEIGHBORS)) ? CW'(MAX_NEIGHBORS) : data_in[CW-1:0];
    pick_ge      = MW'(pick) >= MW'(cnt);
    explore_draw = WORD_WIDTH'(draw) < eps;
    nbr_addr     = ADDR_WIDTH'(NBR_BASE_ADDR + int'(pick) * NBR_STRIDE);
    // Clamp before subtracting so epsilon never wraps below the floor.
    eps_next     = ({1'b0, eps} < ({1'b0, epsilon_step} + (WORD_WIDTH+1)'(EPS_MIN)))
                   ? WORD_WIDTH'(EPS_MIN) : eps - epsilon_step;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = EPS_RD;
      EPS_RD:   state_nxt = DECIDE;
      DECIDE:   state_nxt = explore_draw ? CNT_RD : EXP_MUL;
      CNT_RD:   state_nxt = CNT_WAIT;
      CNT_WAIT: state_nxt = (cnt_clamped == '0) ? EXP_MUL : MOD;
      MOD:      if (!pick_ge) state_nxt = NBR_RD;
      NBR_RD:   state_nxt = NBR_WAIT;
      NBR_WAIT: state_nxt = EPS_WR;
      EPS_WR:   state_nxt = DONE;
      EXP_MUL:  state_nxt = EXP_CMP;
      EXP_CMP:  state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nrst) state <= IDLE;
    else if (en) state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      nexthop  <= WORD_WIDTH'(NO_HOP);
      done     <= 1'b0;
      busy     <= 1'b0;
      rng_en   <= 1'b0;
      wr_en    <= 1'b0;
      explored <= 1'b0;
      address  <= '0;
      data_out <= '0;
      draw     <= '0;
      pick     <= '0;
      eps      <= '0;
      cnt      <= '0;
      l_val    <= '0;
      rdn      <= '0;
      rup      <= '0;
    end else if (en) begin
      done   <= 1'b0;
      rng_en <= 1'b0;
      wr_en  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy     <= 1'b1;
          explored <= 1'b0;
          rng_en   <= 1'b1;
          address  <= ADDR_WIDTH'(EPS_ADDR);
        end
        EPS_RD: begin
          draw <= rng_in;
          eps  <= data_in;
        end
        CNT_RD: begin
          rng_en  <= 1'b1;
          address <= ADDR_WIDTH'(NBR_COUNT_ADDR);
        end
        CNT_WAIT: begin
          pick <= rng_in;
          cnt  <= cnt_clamped;
        end
        MOD: if (pick_ge) pick <= pick - RNG_WIDTH'(cnt);
        NBR_RD: address <= nbr_addr;
        NBR_WAIT: begin
          nexthop  <= data_in;
          explored <= 1'b1;
        end
        EPS_WR: begin
          data_out <= eps_next;
          address  <= ADDR_WIDTH'(EPS_ADDR);
          wr_en    <= 1'b1;
        end
        EXP_MUL: begin
          l_val <= PW'(bestvalue) << 16;
          rdn   <= PW'(mybest) * PW'(HYST_DN);
          rup   <= (PW'(mybest) << 16) + PW'(mybest) * PW'(HYST_UP);
        end
        EXP_CMP: begin
          if (l_val < rdn) nexthop <= besthop;
          else if (l_val < rup && bestneighborID != my_node_id) nexthop <= besthop;
          else nexthop <= WORD_WIDTH'(NO_HOP);
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef WINNER_POLICY_STATS_EN
  always_ff @(posedge clock) begin
    if (!nrst) begin
      explore_count <= '0;
      exploit_count <= '0;
    end else if (en && state == DONE) begin
      if (explored) begin
        if (explore_count != 16'hFFFF) explore_count <= explore_count + 16'd1;
      end else begin
        if (exploit_count != 16'hFFFF) exploit_count <= exploit_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_winner_policy_param.sv
// Bench for winner_policy_param: directed vector table, reset/freeze sequences, and random decisions vs a reference model.
module tb_winner_policy_param;

  typedef struct {
    int eps, draw, cnt, pick, step, mybest, bv, bh, bid, mid, nbr, frz;
    int hop, expl, lat, wr, wdata;
  } vec_t;

  logic        clock = 1'b0;
  logic        nrst, en, start;
  logic [15:0] mybest, bestvalue, besthop, bestneighborID, my_node_id, epsilon_step;
  logic [3:0]  rng_in = '0;
  logic        rng_en, wr_en, explored, busy, done;
  logic [10:0] address;
  logic [15:0] data_in, data_out, nexthop;
`ifdef WINNER_POLICY_STATS_EN
  logic [15:0] explore_count, exploit_count;
`endif

  logic [15:0] mem [0:2047];
  int rq[$];
  int total = 0, bad = 0;
  int wr_cnt = 0, last_wdata = 0, last_waddr = 0, prev_hop = 65;
  int exp_explore = 0, exp_exploit = 0;

  winner_policy_param dut (
    .clock(clock), .nrst(nrst), .en(en), .start(start),
    .mybest(mybest), .bestvalue(bestvalue), .besthop(besthop),
    .bestneighborID(bestneighborID), .my_node_id(my_node_id),
    .epsilon_step(epsilon_step), .rng_in(rng_in), .rng_en(rng_en),
    .address(address), .data_in(data_in), .data_out(data_out), .wr_en(wr_en),
    .nexthop(nexthop), .explored(explored), .busy(busy), .done(done)
`ifdef WINNER_POLICY_STATS_EN
    , .explore_count(explore_count), .exploit_count(exploit_count)
`endif
  );

  always #5 clock = ~clock;

  assign data_in = mem[address];

  always @(posedge clock) begin
    if (en && wr_en) begin
      mem[address] = data_out;
      wr_cnt++;
      last_wdata = int'(data_out);
      last_waddr = int'(address);
    end
  end

  // RNG answers in the cycle the request is visible, so the DUT samples it on the next edge.
  always @(negedge clock) begin
    if (rng_en && en && rq.size() > 0) rng_in = 4'(rq.pop_front());
  end

  task automatic chk(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic vec_t mk(input int eps, draw, cnt, pick, step, mb, bv, bh, bid, mid, nbr, frz,
                              input int hop, expl, lat, wr, wdata);
    vec_t r;
    r.eps = eps; r.draw = draw; r.cnt = cnt; r.pick = pick; r.step = step;
    r.mybest = mb; r.bv = bv; r.bh = bh; r.bid = bid; r.mid = mid; r.nbr = nbr; r.frz = frz;
    r.hop = hop; r.expl = expl; r.lat = lat; r.wr = wr; r.wdata = wdata;
    return r;
  endfunction

  // Reference: modulo/division for the neighbour pick, 64-bit arithmetic for hysteresis.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int c;
    longint l, rd, ru;
    r = v;
    c = (v.cnt > 16) ? 16 : v.cnt;
    if (v.draw < v.eps && c != 0) begin
      r.hop = v.nbr; r.expl = 1; r.lat = 10 + v.pick / c; r.wr = 1;
      r.wdata = (v.eps < v.step) ? 0 : v.eps - v.step;
    end else begin
      l  = longint'(v.bv) * 65536;
      rd = longint'(v.mybest) * 65470;
      ru = longint'(v.mybest) * 65536 + longint'(v.mybest) * 66;
      r.hop = (l < rd || (l < ru && v.bid != v.mid)) ? v.bh : 65;
      r.expl = 0; r.wr = 0; r.wdata = 0;
      r.lat = (v.draw < v.eps) ? 8 : 6;
    end
    r.lat += v.frz;
    return r;
  endfunction

  task automatic load_mem(input vec_t v);
    int c;
    c = (v.cnt > 16) ? 16 : v.cnt;
    mem[4] = 16'(v.eps);
    mem[11'h68C] = 16'(v.cnt);
    for (int i = 0; i < 16; i++) mem[11'h668 + 2 * i] = 16'(1000 + i);
    if (c != 0) mem[11'h668 + 2 * (v.pick % c)] = 16'(v.nbr);
    rq.delete();
    rq.push_back(v.draw);
    rq.push_back(v.pick);
    epsilon_step = 16'(v.step); mybest = 16'(v.mybest); bestvalue = 16'(v.bv);
    besthop = 16'(v.bh); bestneighborID = 16'(v.bid); my_node_id = 16'(v.mid);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, w0;
    load_mem(v);
    w0 = wr_cnt;
    lat = 0;
    start = 1'b1;
    do begin
      @(posedge clock); #1;
      lat++;
      start = 1'b0;
      if (lat == 1) begin
        chk({tag, " busy_start"}, busy, 1);
        chk({tag, " hop_held"}, nexthop, prev_hop);
      end
      if (v.frz > 0 && lat == 3) en = 1'b0;
      if (v.frz > 0 && lat == 3 + v.frz) begin
        chk({tag, " frozen_busy"}, busy, 1);
        chk({tag, " frozen_done"}, done, 0);
        chk({tag, " frozen_hop"}, nexthop, prev_hop);
        en = 1'b1;
      end
    end while (!done && lat < 200);
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " nexthop"}, nexthop, v.hop);
    chk({tag, " explored"}, explored, v.expl);
    chk({tag, " busy_end"}, busy, 0);
    chk({tag, " writes"}, wr_cnt - w0, v.wr);
    if (v.wr != 0) begin
      chk({tag, " wdata"}, last_wdata, v.wdata);
      chk({tag, " waddr"}, last_waddr, 4);
    end
    chk({tag, " mem_eps"}, mem[4], (v.wr != 0) ? v.wdata : v.eps);
    prev_hop = v.hop;
    if (v.expl != 0) exp_explore++; else exp_exploit++;
    @(posedge clock); #1;
    chk({tag, " done_pulse"}, done, 0);
  endtask

  initial begin
    vec_t tbl[9];
    vec_t v;
    int lat, w0, bvi;

    for (int i = 0; i < 2048; i++) mem[i] = '0;
    nrst = 1'b0; en = 1'b1; start = 1'b0;
    mybest = '0; bestvalue = '0; besthop = '0; bestneighborID = '0; my_node_id = '0; epsilon_step = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst nexthop", nexthop, 65);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst rng_en", rng_en, 0);
    chk("rst wr_en", wr_en, 0);
    chk("rst explored", explored, 0);
    chk("rst address", address, 0);
    chk("rst data_out", data_out, 0);
    nrst = 1'b1;
    @(posedge clock); #1;

    //            eps draw cnt pick step  mybest bv   bh bid mid  nbr frz  hop expl lat wr wdata
    tbl[0] = mk(10, 3,  4,  6,  4,   0,    0,   0, 0,  0,   7,   0,   7,   1,  11, 1, 6);
    tbl[1] = mk(10, 3,  4,  1,  12,  0,    0,   0, 0,  0,   9,   0,   9,   1,  10, 1, 0);
    tbl[2] = mk(10, 3,  0,  5,  4,   100,  90,  3, 1,  2,   0,   0,   3,   0,  8,  0, 0);
    tbl[3] = mk(0,  7,  0,  0,  0,   100,  90,  3, 1,  2,   0,   0,   3,   0,  6,  0, 0);
    tbl[4] = mk(0,  7,  0,  0,  0,   1000, 1000,5, 1,  2,   0,   0,   5,   0,  6,  0, 0);
    tbl[5] = mk(0,  7,  0,  0,  0,   1000, 1000,5, 2,  2,   0,   0,   65,  0,  6,  0, 0);
    tbl[6] = mk(0,  0,  0,  0,  0,   100,  200, 8, 1,  2,   0,   5,   65,  0,  11, 0, 0);
    tbl[7] = mk(15, 14, 20, 15, 1,   0,    0,   0, 0,  0,   4660,0,   4660,1,  10, 1, 14);
    tbl[8] = mk(9,  9,  4,  0,  0,   300,  299, 11,1,  2,   0,   0,   11,  0,  6,  0, 0);
    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of the subtraction loop.
    v = mk(12, 2, 1, 15, 3, 0, 0, 0, 0, 0, 85, 0, 0, 0, 0, 0, 0);
    load_mem(v);
    w0 = wr_cnt;
    lat = 0;
    start = 1'b1;
    do begin
      @(posedge clock); #1;
      lat++;
      start = 1'b0;
    end while (lat < 7);
    chk("midrst busy_before", busy, 1);
    nrst = 1'b0;
    @(posedge clock); #1;
    chk("midrst nexthop", nexthop, 65);
    chk("midrst busy", busy, 0);
    chk("midrst wr_en", wr_en, 0);
    chk("midrst done", done, 0);
    nrst = 1'b1;
    repeat (25) @(posedge clock);
    #1;
    chk("midrst writes", wr_cnt - w0, 0);
    chk("midrst mem_eps", mem[4], 12);
    prev_hop = 65;
    exp_explore = 0;
    exp_exploit = 0;

    for (int i = 0; i < 40; i++) begin
      v.eps = int'($urandom_range(0, 15));
      v.draw = int'($urandom_range(0, 15));
      v.cnt = int'($urandom_range(0, 20));
      v.pick = int'($urandom_range(0, 15));
      v.step = int'($urandom_range(0, 15));
      v.mybest = int'($urandom_range(0, 3000));
      if ($urandom_range(0, 1) == 1) begin
        bvi = v.mybest + int'($urandom_range(0, 8)) - 4;
        v.bv = (bvi < 0) ? 0 : bvi;
      end else begin
        v.bv = int'($urandom_range(0, 3000));
      end
      v.bh = int'($urandom_range(0, 60));
      v.bid = int'($urandom_range(0, 1));
      v.mid = int'($urandom_range(0, 1));
      v.nbr = int'($urandom_range(0, 65535));
      v.frz = 0;
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", i));
    end

`ifdef WINNER_POLICY_STATS_EN
    chk("explore_count", explore_count, exp_explore);
    chk("exploit_count", exploit_count, exp_exploit);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
